// File: rtl/des_key_schedule.sv
// des_key_schedule
// Iterative DES key-schedule generator. Latches a 56-bit post-PC-1 key and
// emits the 16 48-bit round subkeys, one per clock: K1..K16 for encryption,
// K16..K1 for decryption.
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   key_in       56-bit C||D key; CD bit n (1..56) = key_in[56-n]
//   decrypt      direction, sampled with load (0 = K1..K16, 1 = K16..K1)
//   load         start request, accepted only when not busy
//   subkey       48-bit round key; subkey bit n (1..48) = subkey[48-n]
//   subkey_valid subkey holds a new round key this cycle
//   round_num    output order index of the emitted key (0..15)
//   busy         schedule in progress
//   done         one-cycle pulse alongside the 16th subkey
module des_key_schedule (
  input  logic        clk,
  input  logic        rst,
  input  logic [55:0] key_in,
  input  logic        decrypt,
  input  logic        load,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  output logic [3:0]  round_num,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE, RUN} state_t;

  // PC-2 selection table, FIPS 46-3 bit numbering (1..56).
  localparam int pc2_tab [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  state_t      state;
  logic [55:0] cd;
  logic [3:0]  ctr;
  logic        mode;

  logic [3:0]  round_idx;
  logic        two;
  logic [55:0] cd_rot_l;
  logic [55:0] cd_rot_r;

  function automatic logic [47:0] pc2(input logic [55:0] k);
    logic [47:0] sel;
    sel = '0;
    for (int n = 1; n <= 48; n++) begin
      sel[48-n] = k[56-pc2_tab[n-1]];
    end
    return sel;
  endfunction

  // Bit 1 of each half sits at the MSB, so a FIPS left rotation moves bits
  // toward the MSB end.
  function automatic logic [27:0] rotl(input logic [27:0] h, input logic by2);
    return by2 ? {h[25:0], h[27:26]} : {h[26:0], h[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] h, input logic by2);
    return by2 ? {h[1:0], h[27:2]} : {h[0], h[27:1]};
  endfunction

  // Zero-based round index for the shift table: decrypt walks it backwards.
  // Rounds 1, 2, 9 and 16 rotate by one; all others by two.
  always_comb begin
    round_idx = mode ? (4'd15 - ctr) : ctr;
    two       = !((round_idx == 4'd0) || (round_idx == 4'd1) ||
                  (round_idx == 4'd8) || (round_idx == 4'd15));
    cd_rot_l  = {rotl(cd[55:28], two), rotl(cd[27:0], two)};
    cd_rot_r  = {rotr(cd[55:28], two), rotr(cd[27:0], two)};
  end

  assign busy = (state == RUN);

  // Encrypt rotates first and emits PC2 of the rotated key; decrypt emits
  // PC2 of the current key and then undoes that round's rotation, so the
  // key register ends each run back at its loaded value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cd           <= '0;
      ctr          <= '0;
      mode         <= 1'b0;
      subkey       <= '0;
      subkey_valid <= 1'b0;
      round_num    <= '0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          subkey_valid <= 1'b0;
          done         <= 1'b0;
          if (load) begin
            cd    <= key_in;
            mode  <= decrypt;
            ctr   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          subkey_valid <= 1'b1;
          round_num    <= ctr;
          ctr          <= ctr + 4'd1;
          if (mode) begin
            subkey <= pc2(cd);
            cd     <= cd_rot_r;
          end else begin
            subkey <= pc2(cd_rot_l);
            cd     <= cd_rot_l;
          end
          if (ctr == 4'd15) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule
// Self-checking bench for des_key_schedule. Expected subkeys come from a
// reference model that applies the cumulative rotation directly to the
// loaded key, plus fixed FIPS vector constants. Each accepted load pushes
// its 16 expected outputs (with the cycle they must appear on) into a
// scoreboard that is drained as subkey_valid is seen.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst;
  logic [55:0] key_in;
  logic        decrypt;
  logic        load;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic [3:0]  round_num;
  logic        busy;
  logic        done;

  des_key_schedule dut (
    .clk          (clk),
    .rst          (rst),
    .key_in       (key_in),
    .decrypt      (decrypt),
    .load         (load),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .round_num    (round_num),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  localparam int pc2_tab [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };
  localparam int shift_tab [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  localparam logic [55:0] key_a   = 56'hF0CCAAF556678F;
  localparam logic [55:0] key_flp = 56'hF0CCAAF556678E;
  localparam logic [55:0] key_b   = 56'h123456789ABCDE;
  localparam logic [55:0] key_c   = 56'hA5A5A5A5A5A5A5;
  localparam logic [47:0] k1_a    = 48'h1B02EFFC7072;
  localparam logic [47:0] k16_a   = 48'hCB3D8B0E17F5;
  localparam logic [47:0] k1_flp  = 48'h1B02EFF87072;

  typedef struct {
    int          cyc;
    logic [47:0] key;
    logic [3:0]  rnd;
    logic        dn;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Round key i (1..16): rotate each half left by the sum of the first i
  // shifts in one step, then apply PC-2.
  function automatic logic [47:0] model_key(input logic [55:0] k, input int rnd);
    int          s;
    int          p;
    int          src;
    logic [47:0] r;
    s = 0;
    r = '0;
    for (int i = 0; i < rnd; i++) s += shift_tab[i];
    for (int n = 1; n <= 48; n++) begin
      p = pc2_tab[n-1];
      if (p <= 28) src = ((p - 1 + s) % 28) + 1;
      else         src = ((p - 29 + s) % 28) + 29;
      r[48-n] = k[56-src];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue the first nr outputs of a run whose load is sampled at edge start.
  task automatic pushRun(input logic [55:0] k, input logic dec, input int start, input int nr);
    exp_t e;
    for (int r = 0; r < nr; r++) begin
      e.cyc = start + 1 + r;
      e.key = dec ? model_key(k, 16 - r) : model_key(k, r + 1);
      e.rnd = r[3:0];
      e.dn  = (r == 15);
      sb.push_back(e);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (subkey_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 64'(subkey_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check("cycle", 64'(cyc), 64'(e.cyc));
        check("subkey", 64'(subkey), 64'(e.key));
        check("round_num", 64'(round_num), 64'(e.rnd));
        check("done", 64'(done), 64'(e.dn));
        check("busy_run", 64'(busy), 64'(!e.dn));
      end
    end else begin
      check("done_idle", 64'(done), 64'd0);
      if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        check("missing_valid", 64'(subkey_valid), 64'd1);
        void'(sb.pop_front());
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic l, input logic dec, input logic [55:0] k);
    rst     = r;
    load    = l;
    decrypt = dec;
    key_in  = k;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    checkOutput();
  endtask

  initial begin
    int start;

    // Reset for two cycles.
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    tick();
    tick();
    check("rst_subkey", 64'(subkey), 64'd0);
    check("rst_valid", 64'(subkey_valid), 64'd0);
    check("rst_round", 64'(round_num), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);

    // Reset wins over a simultaneous load.
    applyStimulus(1'b1, 1'b1, 1'b0, key_a);
    tick();
    check("rst_over_load_busy", 64'(busy), 64'd0);

    // Encrypt, FIPS vector.
    applyStimulus(1'b0, 1'b1, 1'b0, key_a);
    pushRun(key_a, 1'b0, cyc + 1, 16);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, key_a);
    check("enc_busy", 64'(busy), 64'd1);
    for (int r = 0; r < 16; r++) begin
      tick();
      if (r == 0)  check("enc_k1", 64'(subkey), 64'(k1_a));
      if (r == 15) begin
        check("enc_k16", 64'(subkey), 64'(k16_a));
        check("enc_done", 64'(done), 64'd1);
      end
    end

    // Decrypt, same key, loaded on the idle cycle.
    applyStimulus(1'b0, 1'b1, 1'b1, key_a);
    tick();
    check("enc_after_busy", 64'(subkey_valid), 64'd0);
    pushRun(key_a, 1'b1, cyc, 16);
    applyStimulus(1'b0, 1'b0, 1'b0, key_a);
    for (int r = 0; r < 16; r++) begin
      tick();
      if (r == 0)  check("dec_first", 64'(subkey), 64'(k16_a));
      if (r == 15) check("dec_last", 64'(subkey), 64'(k1_a));
    end
    tick();
    check("dec_idle_busy", 64'(busy), 64'd0);

    // Key with bit 0 flipped upstream.
    applyStimulus(1'b0, 1'b1, 1'b0, key_flp);
    pushRun(key_flp, 1'b0, cyc + 1, 16);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, key_flp);
    tick();
    check("flip_k1", 64'(subkey), 64'(k1_flp));
    check("flip_bit18", 64'(subkey ^ k1_a), 64'(48'h1 << 18));
    repeat (16) tick();

    // Load while busy is dropped; a load at N+17 starts a new run.
    applyStimulus(1'b0, 1'b1, 1'b0, key_a);
    start = cyc + 1;
    pushRun(key_a, 1'b0, start, 16);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, key_a);
    while (cyc < start + 4) tick();
    applyStimulus(1'b0, 1'b1, 1'b1, key_b);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, key_a);
    while (cyc < start + 16) tick();
    applyStimulus(1'b0, 1'b1, 1'b0, key_b);
    pushRun(key_b, 1'b0, cyc + 1, 16);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, key_b);
    check("reload_busy", 64'(busy), 64'd1);
    repeat (17) tick();

    // Reset at N+8 abandons the run.
    applyStimulus(1'b0, 1'b1, 1'b0, key_c);
    start = cyc + 1;
    pushRun(key_c, 1'b0, start, 7);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, key_c);
    while (cyc < start + 7) tick();
    applyStimulus(1'b1, 1'b0, 1'b0, key_c);
    tick();
    check("midrst_subkey", 64'(subkey), 64'd0);
    check("midrst_valid", 64'(subkey_valid), 64'd0);
    check("midrst_round", 64'(round_num), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, key_c);
    repeat (20) tick();
    applyStimulus(1'b0, 1'b1, 1'b1, key_c);
    pushRun(key_c, 1'b1, cyc + 1, 16);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, key_c);
    repeat (17) tick();

    // Back-to-back with load held high: runs every 17 cycles.
    for (int run = 0; run < 3; run++) begin
      logic [55:0] k;
      k = (run == 0) ? key_a : (run == 1) ? key_b : key_c;
      applyStimulus(1'b0, 1'b1, (run == 1), k);
      pushRun(k, (run == 1), cyc + 1, 16);
      tick();
      if (run == 2) applyStimulus(1'b0, 1'b0, 1'b0, k);
      repeat (16) tick();
    end
    repeat (3) tick();

    check("sb_empty", 64'(sb.size()), 64'd0);
    check("final_valid", 64'(subkey_valid), 64'd0);
    check("final_busy", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
